// File: rtl/pep_ks_common_param_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pep_ks_common_param_pkg
// Description : Shared key-switch parameters, result/element types and the
//               PBS pointer distance helper.
// Revision    : 1.0
// ============================================================================
package pep_ks_common_param_pkg;

    localparam int LWE_COEF_W   = 32;
    localparam int KS_MS_W      = 12;
    localparam int KS_CORR_W    = 20;
    localparam int BATCH_PBS_NB = 8;
    localparam int TOTAL_PBS_NB = 8;
    localparam int PID_W        = $clog2(TOTAL_PBS_NB);
    localparam int LWE_K        = 10;
    localparam int KS_LOOP_W    = $clog2(LWE_K);

    typedef struct packed {
        logic [KS_LOOP_W-1:0]                     ks_loop;
        logic [PID_W:0]                           wp;
        logic [PID_W:0]                           rp;
        logic [BATCH_PBS_NB-1:0][LWE_COEF_W-1:0] lwe_a;
        logic [BATCH_PBS_NB-1:0][KS_CORR_W-1:0]  corr_a;
    } ks_result_t;

    localparam int KS_RESULT_W = $bits(ks_result_t);

    typedef struct packed {
        logic [KS_MS_W-1:0]   coef;
        logic [PID_W-1:0]     pid;
        logic [KS_LOOP_W-1:0] idx;
        logic                 last;
    } ms_elt_t;

    localparam int MS_ELT_W = $bits(ms_elt_t);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        SERIAL = 1'b1
    } ms_state_e;

    // Pointers carry a wrap bit above the slot index; differing wrap bits
    // mean wp has lapped past the end of the slot range.
    function automatic logic [PID_W:0] pt_elt_nb(input logic [PID_W:0] wp,
                                                 input logic [PID_W:0] rp);
        logic [PID_W:0] n;
        if (wp[PID_W] == rp[PID_W])
            n = {1'b0, wp[PID_W-1:0]} - {1'b0, rp[PID_W-1:0]};
        else
            n = (PID_W+1)'(TOTAL_PBS_NB) - {1'b0, rp[PID_W-1:0]} + {1'b0, wp[PID_W-1:0]};
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pep_ks_result_modswitch_fifo_reg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_reg
// Description : Register-based circular FIFO with synchronous flush.
// Revision    : 1.0
// ============================================================================
module fifo_reg #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             a_rst_n,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_vld,
    output logic             o_rdy,
    output logic [WIDTH-1:0] o_data,
    output logic             o_vld,
    input  logic             i_rdy
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [c_PTR_W-1:0] c_LAST_PTR = c_PTR_W'(DEPTH - 1);
    localparam logic [c_CNT_W-1:0] c_FULL     = c_CNT_W'(DEPTH);

    logic [WIDTH-1:0]   r_mem [0:DEPTH-1];
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_CNT_W-1:0] r_cnt;
    logic               w_push;
    logic               w_pop;

    assign o_rdy  = (r_cnt != c_FULL);
    assign o_vld  = (r_cnt != '0);
    assign o_data = r_mem[r_rptr];
    assign w_push = i_vld & o_rdy;
    assign w_pop  = o_vld & i_rdy;

    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else if (i_flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push)
                r_wptr <= (r_wptr == c_LAST_PTR) ? '0 : r_wptr + c_PTR_W'(1);
            if (w_pop)
                r_rptr <= (r_rptr == c_LAST_PTR) ? '0 : r_rptr + c_PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + c_CNT_W'(1);
                2'b01:   r_cnt <= r_cnt - c_CNT_W'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !i_flush)
            r_mem[r_wptr] <= i_data;
    end

endmodule
`default_nettype wire

// File: rtl/pep_ks_result_modswitch.sv
`default_nettype none
// ============================================================================
// Module      : pep_ks_result_modswitch
// Description : Serializes key-switch results into per-PBS coefficients and
//               mod-switches each one to 2N with round-to-nearest.
// Revision    : 1.0
// ============================================================================
module pep_ks_result_modswitch
    import pep_ks_common_param_pkg::*;
#(
    parameter int OUT_FIFO_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   a_rst_n,
    input  logic [KS_RESULT_W-1:0] ks_seq_result,
    input  logic                   ks_seq_result_vld,
    output logic                   ks_seq_result_rdy,
    input  logic                   reset_cache,
    output logic [KS_MS_W-1:0]     ms_wr_coef,
    output logic [PID_W-1:0]       ms_wr_pid,
    output logic [KS_LOOP_W-1:0]   ms_wr_idx,
    output logic                   ms_wr_last,
    output logic                   ms_wr_vld,
    input  logic                   ms_wr_rdy
);

    localparam int c_SH = LWE_COEF_W - KS_MS_W;
    localparam logic [LWE_COEF_W:0]  c_RND      = (LWE_COEF_W+1)'(1) << (c_SH - 1);
    localparam logic [PID_W-1:0]     c_CNT_MAX  = PID_W'(BATCH_PBS_NB - 1);
    localparam logic [KS_LOOP_W-1:0] c_LAST_LOOP = KS_LOOP_W'(LWE_K - 1);

    ms_state_e        r_state;
    ms_state_e        w_state_nxt;
    logic [PID_W-1:0] r_cnt;
    logic [PID_W-1:0] w_cnt_nxt;
    logic             r_reset_loop;
    logic             r_rdy_en;
    ks_result_t       r_res;
    ks_result_t       w_in;

    logic [PID_W:0]        w_n;
    logic [PID_W:0]        w_in_n;
    logic                  w_last;
    logic                  w_issue;
    logic                  w_load;
    logic                  w_fifo_in_rdy;
    logic                  w_fifo_out_vld;
    logic [LWE_COEF_W-1:0] w_sum;
    logic [LWE_COEF_W:0]   w_rnd;
    logic [PID_W:0]        w_pid_full;
    ms_elt_t               w_elt;
    ms_elt_t               w_out;

    assign w_in    = ks_seq_result;
    assign w_n     = pt_elt_nb(r_res.wp, r_res.rp);
    assign w_in_n  = pt_elt_nb(w_in.wp, w_in.rp);
    assign w_last  = (({1'b0, r_cnt} + (PID_W+1)'(1)) == w_n);
    assign w_issue = (r_state == SERIAL) & w_fifo_in_rdy & ~r_reset_loop;

    assign ks_seq_result_rdy = r_rdy_en &
                               ((r_state == IDLE) | (w_issue & w_last) | r_reset_loop);
    // Empty results (wp == rp) are consumed without entering SERIAL.
    assign w_load = ks_seq_result_vld & ks_seq_result_rdy & ~r_reset_loop & (w_in_n != '0);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (r_reset_loop) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_load) begin
                        w_state_nxt = SERIAL;
                        w_cnt_nxt   = '0;
                    end
                end
                SERIAL: begin
                    if (w_issue) begin
                        if (w_last) begin
                            w_cnt_nxt   = '0;
                            w_state_nxt = w_load ? SERIAL : IDLE;
                        end else begin
                            w_cnt_nxt = (r_cnt == c_CNT_MAX) ? '0 : r_cnt + PID_W'(1);
                        end
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_reset_loop <= 1'b0;
            r_rdy_en     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_reset_loop <= reset_cache;
            r_rdy_en     <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_load)
            r_res <= w_in;
    end

    // Round to nearest on one extra bit; the top bits fold back to 0 at 2N.
    always_comb begin
        w_sum      = r_res.lwe_a[r_cnt] + LWE_COEF_W'(r_res.corr_a[r_cnt]);
        w_rnd      = {1'b0, w_sum} + c_RND;
        w_pid_full = {1'b0, r_res.rp[PID_W-1:0]} + {1'b0, r_cnt};
        w_elt.coef = w_rnd[c_SH +: KS_MS_W];
        w_elt.pid  = w_pid_full[PID_W-1:0];
        w_elt.idx  = r_res.ks_loop;
        w_elt.last = w_last & (r_res.ks_loop == c_LAST_LOOP);
    end

    fifo_reg #(
        .WIDTH (MS_ELT_W),
        .DEPTH (OUT_FIFO_DEPTH)
    ) u_out_fifo (
        .clk     (clk),
        .a_rst_n (a_rst_n),
        .i_flush (r_reset_loop),
        .i_data  (w_elt),
        .i_vld   (w_issue),
        .o_rdy   (w_fifo_in_rdy),
        .o_data  (w_out),
        .o_vld   (w_fifo_out_vld),
        .i_rdy   (ms_wr_rdy & ~r_reset_loop)
    );

    assign ms_wr_vld  = w_fifo_out_vld & ~r_reset_loop;
    assign ms_wr_coef = w_out.coef;
    assign ms_wr_pid  = w_out.pid;
    assign ms_wr_idx  = w_out.idx;
    assign ms_wr_last = w_out.last & ms_wr_vld;

endmodule
`default_nettype wire
